dmem_responder: RTL and testbench

- Data-memory responder: the memory-side end of the CPU load/store interface (address, write data, write strobe, read data).
- Accepts one word request at a time through a req/ready handshake, models a configurable access latency, then returns a one-cycle completion pulse with read data or an error flag.
- Sits between the pipeline's memory stage and the data segment; the pipeline stalls on `ready`/`done`.

---
 rtl/dmem_responder.sv | 117 +++++++++++
 tb/tb_dmem_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: memory-side end of the CPU load/store interface.
// Accepts one word request at a time through a req/ready handshake, waits
// LATENCY cycles, then pulses done for one cycle with read data or an error.
module dmem_responder #(
  parameter int          DEPTH     = 1024,          // words, power of two, >= 2
  parameter logic [31:0] BASE_ADDR = 32'h10010000,  // byte address of word 0
  parameter int          LATENCY   = 2              // wait cycles, 0..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Upper bound of the data segment, one bit wider so it cannot wrap.
  localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + 33'(DEPTH) * 33'd4;
  localparam bit          ZERO_LAT = (LATENCY == 0);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          commit;
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic          fault;
  logic [AW-1:0] idx;

  assign ready  = (state == S_IDLE);
  assign done   = (state == S_DONE);
  assign accept = ready && req;

  // The access resolves on the edge that enters DONE. With zero latency that
  // is the acceptance edge itself, so the live inputs are used instead of the
  // captured copy.
  assign commit    = ZERO_LAT ? accept : ((state == S_WAIT) && (cnt == 4'd1));
  assign acc_we    = (state == S_IDLE) ? we    : cap_we;
  assign acc_addr  = (state == S_IDLE) ? addr  : cap_addr;
  assign acc_wdata = (state == S_IDLE) ? wdata : cap_wdata;

  // Misaligned or outside [BASE_ADDR, BASE_ADDR + 4*DEPTH) faults.
  assign fault = (acc_addr[1:0] != 2'b00) ||
                 ({1'b0, acc_addr} < {1'b0, BASE_ADDR}) ||
                 ({1'b0, acc_addr} >= LIMIT);

  // BASE_ADDR is word aligned, so the low bits of (addr - BASE_ADDR) >> 2
  // depend only on the low address bits.
  assign idx = acc_addr[AW+1:2] - BASE_ADDR[AW+1:2];

  // Handshake FSM, wait counter, request capture and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      cap_we    <= 1'b0;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
      rdata     <= 32'd0;
      err       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      unique case (state)
        S_IDLE: begin
          if (req) begin
            cap_we    <= we;
            cap_addr  <= addr;
            cap_wdata <= wdata;
            if (ZERO_LAT) begin
              state <= S_DONE;
            end else begin
              cnt   <= 4'(LATENCY);
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (commit) begin
        err   <= fault;
        rdata <= (fault || acc_we) ? 32'd0 : mem[idx];
      end
    end
  end

  // Legal stores commit on the edge entering DONE; a reset aborts them.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; contents stay undefined until written.
    if (commit && acc_we && !fault && !rst) begin
      mem[idx] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder. Two instances share the
// request bus: one with LATENCY=2, one with LATENCY=0. Expected responses come
// from a reference memory model and travel through a scoreboard queue.
module tb_dmem_responder;

  localparam longint unsigned BASE  = 64'h10010000;
  localparam int              DEPTH = 1024;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req1 = 1'b0;
  logic        req0 = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;

  logic        ready1, done1, err1;
  logic [31:0] rdata1;
  logic        ready0, done0, err0;
  logic [31:0] rdata0;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t        exp_q [$];
  logic [31:0] mem_m1 [int];
  logic [31:0] mem_m0 [int];

  dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(32'h10010000), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst), .req(req1), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready1), .done(done1), .rdata(rdata1), .err(err1)
  );

  dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(32'h10010000), .LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready0), .done(done0), .rdata(rdata0), .err(err0)
  );

  always #5 clk = ~clk;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int which);
    return (which == 0) ? ready0 : ready1;
  endfunction

  function automatic logic dn(input int which);
    return (which == 0) ? done0 : done1;
  endfunction

  function automatic logic [31:0] rd(input int which);
    return (which == 0) ? rdata0 : rdata1;
  endfunction

  function automatic logic er(input int which);
    return (which == 0) ? err0 : err1;
  endfunction

  // Reference behaviour of one access; updates the model memory on legal stores.
  function automatic exp_t model_access(input int which, input logic w,
                                        input logic [31:0] a, input logic [31:0] d);
    exp_t            e;
    longint unsigned la;
    int              wi;
    bit              bad;
    la  = 64'(a);
    bad = (a[1:0] != 2'b00) || (la < BASE) || (la > BASE + 4 * DEPTH - 4);
    wi  = int'((la - BASE) >> 2);
    e.rdata = 32'd0;
    e.err   = bad;
    if (!bad) begin
      if (w) begin
        if (which == 0) mem_m0[wi] = d;
        else            mem_m1[wi] = d;
      end else if (which == 0) begin
        e.rdata = mem_m0.exists(wi) ? mem_m0[wi] : 'x;
      end else begin
        e.rdata = mem_m1.exists(wi) ? mem_m1[wi] : 'x;
      end
    end
    return e;
  endfunction

  // One full transaction: wait for ready, drive, scramble inputs after
  // acceptance, wait (bounded) for done, then compare against the scoreboard.
  task automatic request(input int which, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input string tag);
    exp_t e;
    int   k;
    int   lat;
    lat = (which == 0) ? 0 : 2;
    @(negedge clk);
    k = 0;
    while (!rdy(which) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(32'(rdy(which)), 32'd1, {tag, "/ready"});
    exp_q.push_back(model_access(which, w, a, d));
    we    = w;
    addr  = a;
    wdata = d;
    if (which == 0) req0 = 1'b1;
    else            req1 = 1'b1;
    @(posedge clk);
    #1;
    req0  = 1'b0;
    req1  = 1'b0;
    we    = 1'($urandom);
    addr  = $urandom;
    wdata = $urandom;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (dn(which)) break;
      check(32'(rdy(which)), 32'd0, {tag, "/busy"});
    end
    check(32'(k), 32'(lat + 1), {tag, "/latency"});
    check(32'(rdy(which)), 32'd0, {tag, "/ready_at_done"});
    e = exp_q.pop_front();
    check(rd(which), e.rdata, {tag, "/rdata"});
    check(32'(er(which)), 32'(e.err), {tag, "/err"});
  endtask

  initial begin
    int acc_cnt;
    int done_cnt;

    // Reset release with an idle bus.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check(32'(ready1), 32'd1, "idle/ready1");
      check(32'(done1), 32'd0, "idle/done1");
      check(32'(err1), 32'd0, "idle/err1");
      check(rdata1, 32'd0, "idle/rdata1");
      check(32'(ready0), 32'd1, "idle/ready0");
      check(32'(done0), 32'd0, "idle/done0");
    end

    // Store then load with LATENCY=2.
    request(1, 1'b1, 32'h10010004, 32'hCAFEF00D, "st_w1");
    request(1, 1'b1, 32'h10010008, 32'hDEADBEEF, "st_w2");
    request(1, 1'b0, 32'h10010008, 32'h0, "ld_w2");

    // Segment boundaries and address wrap.
    request(1, 1'b1, 32'h10010FFC, 32'hA5A50FFC, "st_last");
    request(1, 1'b0, 32'h10010FFC, 32'h0, "ld_last");
    request(1, 1'b0, 32'h10011000, 32'h0, "ld_past_end");
    request(1, 1'b0, 32'h1000FFFC, 32'h0, "ld_below_base");
    request(1, 1'b0, 32'hFFFFFFFC, 32'h0, "ld_top");
    request(1, 1'b1, 32'h10010000, 32'h0000F00F, "st_first");
    request(1, 1'b0, 32'h10010000, 32'h0, "ld_first");

    // Misaligned store: faults, writes nothing, err holds after done falls.
    request(1, 1'b1, 32'h10010006, 32'h12345678, "st_misaligned");
    @(negedge clk);
    check(32'(done1), 32'd0, "err_hold/done");
    check(32'(err1), 32'd1, "err_hold/err");
    request(1, 1'b0, 32'h10010004, 32'h0, "ld_w1_after_mis");
    request(1, 1'b0, 32'h10010008, 32'h0, "ld_w2_after_mis");

    // Zero-latency instance.
    request(0, 1'b1, 32'h10010100, 32'h0BADF00D, "l0_st");
    request(0, 1'b0, 32'h10010100, 32'h0, "l0_ld");

    // req held high for 20 cycles on the zero-latency instance: accepted on
    // every other edge, one done per acceptance.
    acc_cnt  = 0;
    done_cnt = 0;
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      check(32'(ready0), 32'((k % 2) == 0), "hold/ready");
      check(32'(done0), 32'((k % 2) == 1), "hold/done");
      if (done0) done_cnt++;
      we    = 1'b1;
      addr  = 32'(BASE) + 32'(4 * k);
      wdata = 32'hB0000000 + 32'(k);
      req0  = 1'b1;
      if (ready0) begin
        acc_cnt++;
        mem_m0[k] = wdata;
      end
      @(negedge clk);
    end
    req0 = 1'b0;
    if (done0) done_cnt++;
    check(32'(acc_cnt), 32'd10, "hold/accepts");
    check(32'(done_cnt), 32'd10, "hold/dones");
    request(0, 1'b0, 32'h10010008, 32'h0, "hold_rb2");
    request(0, 1'b0, 32'h10010018, 32'h0, "hold_rb6");

    // Reset during WAIT aborts the store.
    request(1, 1'b1, 32'h10010010, 32'h11111111, "pre_rst_st");
    @(negedge clk);
    we    = 1'b1;
    addr  = 32'h10010010;
    wdata = 32'h99999999;
    req1  = 1'b1;
    @(posedge clk);
    #1;
    req1 = 1'b0;
    @(negedge clk);
    check(32'(ready1), 32'd0, "rst_mid/in_wait");
    #1 rst = 1'b1;
    #1;
    check(32'(ready1), 32'd1, "rst_mid/ready_async");
    #1 rst = 1'b0;
    #1;
    check(32'(ready1), 32'd1, "rst_mid/ready_after");
    check(32'(done1), 32'd0, "rst_mid/done_after");
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check(32'(done1), 32'd0, "rst_mid/no_done");
    end
    check(rdata1, 32'd0, "rst_mid/rdata");
    check(32'(err1), 32'd0, "rst_mid/err");
    request(1, 1'b0, 32'h10010010, 32'h0, "ld_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
